// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out a
// start/data/parity/stop frame on device clock falls, then check the ACK.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, tx_ready high, waiting for tx_valid
// INHIBIT   | PS/2 clock held low for INHIBIT_CYCLES
// RTS       | clock and data (start bit) both held low for RTS_CYCLES
// SEND      | clock released; one frame bit presented per device fall
// ACK       | stop presented; next fall samples the device ACK
// WAIT_IDLE | ACK good; wait for both lines high before reporting done
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          TO_W    = 20;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dly_cnt, dly_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic [9:0]       frame, frame_nxt;
  logic             clk_oe_nxt, data_oe_nxt, done_nxt, err_nxt;
  logic             clk_meta, clk_sync, clk_prev;
  logic             data_meta, data_sync;
  logic             fall, timeout;

  assign fall     = clk_prev & ~clk_sync;
  assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign tx_ready = (state == IDLE);

  always_ff @(posedge master_clk) begin
    if (reset) begin
      clk_meta    <= 1'b1;
      clk_sync    <= 1'b1;
      clk_prev    <= 1'b1;
      data_meta   <= 1'b1;
      data_sync   <= 1'b1;
      state       <= IDLE;
      dly_cnt     <= '0;
      to_cnt      <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      clk_meta    <= ps2_clk_in;
      clk_sync    <= clk_meta;
      clk_prev    <= clk_sync;
      data_meta   <= ps2_data_in;
      data_sync   <= data_meta;
      state       <= state_nxt;
      dly_cnt     <= dly_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      frame       <= frame_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    to_cnt_nxt  = '0;
    bit_idx_nxt = bit_idx;
    frame_nxt   = frame;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    // The watchdog only runs while the device owns the clock.
    if (state == SEND || state == ACK || state == WAIT_IDLE)
      to_cnt_nxt = fall ? '0 : to_cnt + TO_W'(1);

    unique case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_valid) begin
          frame_nxt   = {1'b1, ~^tx_data, tx_data};
          dly_cnt_nxt = CNT_W'(INHIBIT_CYCLES - 1);
          clk_oe_nxt  = 1'b1;
          state_nxt   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (dly_cnt == '0) begin
          dly_cnt_nxt = CNT_W'(RTS_CYCLES - 1);
          data_oe_nxt = 1'b1;
          state_nxt   = RTS;
        end else begin
          dly_cnt_nxt = dly_cnt - CNT_W'(1);
        end
      end
      RTS: begin
        if (dly_cnt == '0) begin
          clk_oe_nxt  = 1'b0;
          bit_idx_nxt = '0;
          to_cnt_nxt  = '0;
          state_nxt   = SEND;
        end else begin
          dly_cnt_nxt = dly_cnt - CNT_W'(1);
        end
      end
      SEND: begin
        if (timeout) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end else if (fall) begin
          data_oe_nxt = ~frame[bit_idx];
          bit_idx_nxt = bit_idx + 4'd1;
          if (bit_idx == 4'd9)
            state_nxt = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end else if (fall) begin
          if (data_sync) begin
            data_oe_nxt = 1'b0;
            err_nxt     = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end else if (clk_sync && data_sync) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, the number of master_clk cycles the PS/2 clock is held low before a request-to-send (100 us at 50 MHz).
REQ-002 The block SHALL have parameter RTS_CYCLES, default 50, the number of master_clk cycles that clock and data are both held low before the clock is released.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum number of master_clk cycles allowed between device clock falling edges (20 ms).
REQ-004 The block SHALL have port master_clk, input, 1, the 50 MHz system clock and its only clock.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port tx_data, input, 8, the command byte to send to the keyboard.
REQ-007 The block SHALL have port tx_valid, input, 1, a request to send tx_data.
REQ-008 The block SHALL have port tx_ready, output, 1, which is high only when the block can accept a byte.
REQ-009 The block SHALL have port ps2_clk_in, input, 1, the raw PS/2 clock line (KB_clk), which is asynchronous.
REQ-010 The block SHALL have port ps2_data_in, input, 1, the raw PS/2 data line, which is asynchronous.
REQ-011 The block SHALL have port ps2_clk_oe, output, 1, where 1 pulls the PS/2 clock low and 0 releases it (open-drain).
REQ-012 The block SHALL have port ps2_data_oe, output, 1, where 1 pulls the PS/2 data line low and 0 releases it.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when the device acknowledges the byte.
REQ-014 The block SHALL have port err, output, 1, a one-cycle pulse when a transfer is aborted by timeout or a missing ACK.

Function
REQ-015 Both ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers, and a falling edge (fall) SHALL be defined as previous synchronized clock = 1 and current = 0.
REQ-016 The block SHALL accept a byte when tx_valid and tx_ready are both high; it SHALL latch tx_data, compute odd parity (parity = ~^tx_data), and enter INHIBIT on the next cycle.
REQ-017 tx_valid SHALL be ignored whenever tx_ready is 0.
REQ-018 The state machine SHALL have the states IDLE, INHIBIT, RTS, SEND, ACK and WAIT_IDLE, and tx_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, both oe outputs SHALL be 0.
REQ-020 In INHIBIT, clk_oe SHALL be 1 and data_oe 0 for exactly INHIBIT_CYCLES cycles, then the block SHALL go to RTS.
REQ-021 In RTS, clk_oe and data_oe (start bit 0) SHALL both be 1 for RTS_CYCLES cycles, then the block SHALL go to SEND with clk_oe = 0 and the bit index = 0.
REQ-022 In SEND, on each fall, the block SHALL drive frame bit k (data bits 0..7 LSB-first, then parity at k = 8, then stop at k = 9), with data_oe = ~bit.
REQ-023 Stop SHALL mean data_oe = 0; after the fall that presents stop, the block SHALL go to ACK.
REQ-024 In ACK, on the next fall, the block SHALL sample the synchronized data: 0 means the ACK is good and the block goes to WAIT_IDLE; 1 means it pulses err and goes to IDLE.
REQ-025 In WAIT_IDLE, once both synchronized lines are high, the block SHALL pulse done and go to IDLE.
REQ-026 The timeout timer (20 bits) SHALL clear on entry to SEND and on every fall.
REQ-027 In SEND, ACK and WAIT_IDLE, if the timer reaches TIMEOUT_CYCLES, the block SHALL release both lines, pulse err and go to IDLE.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 Each is a single-cycle pulse.
REQ-030 A fall seen during INHIBIT or RTS (a device glitch) SHALL be ignored.
REQ-031 The line drive is registered: oe changes SHALL appear on the cycle after the state/edge decision.
REQ-032 After done or err, tx_ready SHALL be 1 on the same cycle as the IDLE entry, and a back-to-back tx_valid SHALL be accepted then.

Reset
REQ-033 On reset = 1 at a master_clk edge, the block SHALL enter IDLE and set tx_ready = 1, ps2_clk_oe = 0, ps2_data_oe = 0, done = 0 and err = 0, and it SHALL clear the timer, bit index and synchronizers (synchronizers to 1).
REQ-034 A reset mid-transfer SHALL abort the transfer with no done or err pulse, and the lines SHALL be released on the next cycle.

Verification
REQ-035 Send tx_data = 0xED with a device model sending ACK: data_oe over falls 1..10 = ~{1,0,1,1,0,1,1,1, p=1, stop} and clk_oe held for 5000 cycles, with a single done pulse and no err.
REQ-036 Send tx_data = 0x07: the parity bit is 0 (data_oe = 1 at the 9th fall) and done is asserted.
REQ-037 Send tx_data = 0xFF with the device leaving data high at the 11th fall: err pulses once, no done, and the block returns to IDLE.
REQ-038 With the device providing no clock after RTS: err pulses at TIMEOUT_CYCLES after SEND entry and both oe are 0.
REQ-039 Assert reset during SEND after the 4th fall: both oe are 0 and tx_ready = 1 the next cycle, with no done or err; a following 0xF4 completes normally.
REQ-040 Hold tx_valid continuously with 0xED then 0xF4: both bytes are sent in order, the second INHIBIT starts the cycle after the first done, and tx_valid is ignored while busy.
